// File: rtl/ir_uart_rx.sv
// ============================================================================
// Module   : ir_uart_rx
// Brief    : 8N1 serial receiver feeding IR_decoder. It has a one-deep holding
//            register with a valid/ack handshake and framing/overrun flags.
//            Optional macro IR_RX_MAJORITY_EN selects 2-of-3 majority sampling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_uart_rx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // Majority voting decides one cycle after the nominal point. Restarting the
    // counter at 1 keeps every later sample point on its usual position.
`ifdef IR_RX_MAJORITY_EN
    localparam int c_OFS = 1;
`else
    localparam int c_OFS = 0;
`endif
    localparam logic [CNT_W-1:0] c_START_PT = CNT_W'(HALF_BIT - 1 + c_OFS);
    localparam logic [CNT_W-1:0] c_BIT_PT   = CNT_W'(CLKS_PER_BIT - 1 + c_OFS);
    localparam logic [CNT_W-1:0] c_CNT_RST  = CNT_W'(c_OFS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             w_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef IR_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    // r_hist[1], r_hist[0] and r_rx_s are the line at nominal -1, 0 and +1.
    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == c_START_PT) begin
                        r_cnt     <= c_CNT_RST;
                        r_bit_idx <= '0;
                        r_state   <= w_sample ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_BIT_PT) begin
                        r_cnt              <= c_CNT_RST;
                        r_shift[r_bit_idx] <= w_sample;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_BIT_PT) begin
                        r_cnt <= c_CNT_RST;
                        if (w_sample) begin
                            // A load overrides a same-cycle ack, so valid stays set.
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            if (r_rx_valid && !rx_ack) begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ir_uart_rx.sv
// ============================================================================
// Module   : tb_ir_uart_rx
// Brief    : Self-checking bench for ir_uart_rx with CLKS_PER_BIT=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_ov;
    } vec_t;
    vec_t vecs[6];

    ir_uart_rx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rx value per clock: slot 0 start, slots 1..8 data LSB first, then stop.
    task automatic send(input logic [7:0] b, input bit stop_bit, input bit glitch, input int ncyc);
        for (int e = 0; e < ncyc; e++) begin
            int   slot;
            logic v;
            slot = e / C;
            if (slot == 0) v = 1'b0;
            else if (slot <= 8) v = b[slot-1];
            else v = stop_bit;
            if (glitch && slot >= 1 && slot <= 8 && (e % C) == H) v = ~v;
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * C; i++) begin
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_byte(input string name, input bit exp_ov);
        bit         ok;
        logic [7:0] e;
        wait_valid(ok);
        check($sformatf("%s_valid", name), 32'(ok), 32'd1);
        e = exp_q.pop_front();
        check($sformatf("%s_data", name), 32'(rx_data), 32'(e));
        check($sformatf("%s_overrun", name), 32'(overrun), 32'(exp_ov));
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        int busy_low;
        int valid_hi;

        vecs[0] = '{8'h41, 1'b1, 1'b0};
        vecs[1] = '{8'h26, 1'b1, 1'b0};
        vecs[2] = '{8'hC6, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h02, 1'b0, 1'b1};

        idle_cycles(3);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle_cycles(4);

        base = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].data);
            send(vecs[i].data, 1'b1, 1'b0, 10 * C);
            expect_byte($sformatf("vec%0d", i), vecs[i].exp_ov);
            if (vecs[i].ack) begin
                pulse_ack();
                check($sformatf("vec%0d_ack_valid", i), 32'(rx_valid), 32'd0);
                check($sformatf("vec%0d_ack_overrun", i), 32'(overrun), 32'd0);
            end
        end
        pulse_ack();
        check("ovr_ack_valid", 32'(rx_valid), 32'd0);
        check("ovr_ack_overrun", 32'(overrun), 32'd0);
        check("vec_no_frame_err", 32'(fe_cnt - base), 32'd0);

        // Short low pulse shorter than half a bit.
        base = fe_cnt;
        send(8'h00, 1'b1, 1'b0, 5);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        @(negedge clk);
        rx = 1'b1;
        idle_cycles(2 * C);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - base), 32'd0);

        // Framing error followed by a 40-bit break.
        base = fe_cnt;
        busy_low = 0;
        valid_hi = 0;
        send(8'h55, 1'b0, 1'b0, 10 * C);
        for (int i = 0; i < 40 * C; i++) begin
            @(negedge clk);
            rx = 1'b0;
            if (busy !== 1'b1) busy_low++;
            if (rx_valid !== 1'b0) valid_hi++;
        end
        check("frm_pulses", 32'(fe_cnt - base), 32'd1);
        check("frm_busy_drop", 32'(busy_low), 32'd0);
        check("frm_valid", 32'(valid_hi), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        idle_cycles(4);
        check("frm_busy_release", 32'(busy), 32'd0);
        check("frm_valid_after", 32'(rx_valid), 32'd0);

        // Reset in the middle of a frame while a byte is still held.
        idle_cycles(2);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0, 10 * C);
        expect_byte("pre_rst", 1'b0);
        send(8'hAA, 1'b1, 1'b0, 5 * C);
        #2;
        rst = 1'b0;
        #1;
        check("arst_data", 32'(rx_data), 32'h00);
        check("arst_valid", 32'(rx_valid), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        idle_cycles(2);
        rx = 1'b1;
        rst = 1'b1;
        idle_cycles(5);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0, 10 * C);
        expect_byte("post_rst", 1'b0);
        pulse_ack();
        check("post_rst_ack", 32'(rx_valid), 32'd0);

`ifdef IR_RX_MAJORITY_EN
        idle_cycles(3);
        exp_q.push_back(8'hAA);
        send(8'hAA, 1'b1, 1'b1, 10 * C);
        expect_byte("maj", 1'b0);
        pulse_ack();
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ir_uart_rx.md
Name: ir_uart_rx

Overview:
- Serial receiver that sits directly upstream of IR_decoder.
- Converts the asynchronous IR/UART line `rx` into 8-bit bytes: 8N1 format, LSB first, 9600 baud from the 25 MHz system clock.
- Presents each byte through a one-deep holding register with a valid/ack handshake.
- Flags framing and overrun errors so the decoder can discard corrupt command packets.

Parameters:
- CLKS_PER_BIT, 2604: system clocks per bit (25 MHz / 9600). Legal range 8..65535.
- HALF_BIT, CLKS_PER_BIT/2: offset from the start edge to the start-bit validation sample.
- CNT_W, 16: width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, 25 MHz.
- rst  input  1  reset, asynchronous, active-low.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer has taken rx_data; clears rx_valid.
- rx_data  output  8  received byte, stable while rx_valid=1.
- rx_valid  output  1  holding register contains an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte was completed while rx_valid=1; cleared by rx_ack.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - Synchroniser flops set to 1; state=IDLE; counters=0.
  - Reset mid-frame abandons the frame immediately.
- Synchroniser:
  - rx passes through 2 flops; rx_s is the second flop.
  - All decisions use rx_s, so there are 2 cycles of latency from the pin.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s=0 → START, counter cleared.
  - Otherwise stay in IDLE.
- START:
  - At counter=HALF_BIT-1, sample rx_s.
  - Sample 0 → DATA, counter cleared, bit index=0.
  - Sample 1 → IDLE. This is a glitch; no error is flagged.
- DATA:
  - Every CLKS_PER_BIT cycles (counter=CLKS_PER_BIT-1), sample rx_s into shift[bit_idx]. LSB first.
  - After bit index 7 is sampled → STOP.
  - Counter and index wrap to 0 at each sample.
- STOP (sample after CLKS_PER_BIT cycles):
  - Sample 1, valid frame:
    - rx_data<=shift and rx_valid<=1 on the next edge.
    - If rx_valid was already 1 and rx_ack is not asserted in that same cycle: overrun<=1, and the new byte still overwrites rx_data.
    - Go to IDLE.
  - Sample 0, framing error:
    - frame_err=1 for exactly one cycle; holding register unchanged.
    - Go to WAIT_IDLE.
- WAIT_IDLE (break or line stuck low):
  - Stay until rx_s=1 for one cycle, then → IDLE.
  - No bytes are produced in this state.
- Handshake:
  - rx_ack=1 for one cycle clears rx_valid and overrun on the next edge.
  - rx_ack while rx_valid=0 is ignored.
  - Load and ack in the same cycle: the load wins, so rx_valid=1 with the new data; overrun is not set.
- Timing:
  - Start-edge-to-mid-bit sample error ≤ 2 clk + 1 clk quantisation; this is well inside ±5% of the bit period.
  - rx_valid rises 1 cycle after the stop sample, i.e. about 9.5 bit times after the start edge plus 3 cycles.

Optional Feature:
- Macro: IR_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start validation, data bits, stop) takes three rx_s samples at counter offsets −1, 0, +1 around the nominal point.
  - The bit value is the 2-of-3 majority.
  - The sampling decision is made 1 cycle later; all other timing is unchanged.
  - Requires CLKS_PER_BIT ≥ 8.
- Undefined: a single sample at the nominal point.

Test Plan:
- CLKS_PER_BIT=16; after reset, send byte 0x41 (the reset-command pattern) → rx_data=8'h41, rx_valid=1, frame_err=0. Assert rx_ack → rx_valid=0 next cycle.
- Send 0x26, 0xC6, then 0x80 back-to-back with rx_ack pulsed after each byte → three bytes received in order, with overrun never set.
- Send 0x01 and 0x02 with no ack → rx_data=8'h02, overrun=1. Pulse rx_ack → rx_valid=0, overrun=0.
- Send 0x55 with the stop bit forced 0, then hold rx low 40 bit times → frame_err pulses once, rx_valid stays 0, busy stays 1 until rx returns high.
- Drive a rx low pulse of 5 clocks (< HALF_BIT) → state returns to IDLE, no byte, no error.
- Assert rst low in the middle of the data bits of 0xAA, release, then send 0x3C → outputs return to reset values immediately, then rx_data=8'h3C.
- With IR_RX_MAJORITY_EN defined: inject a 1-clock glitch exactly at each data bit's nominal sample point of 0xAA → 0xAA is received correctly.
